mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Data-memory access controller for the MEM stage. Turns MEMP load/store requests into a single-outstanding
//  valid/ready bus transaction. Produces the 2-bit memory state consumed by the hazard unit, which stalls the
//  whole pipeline while state != 0. Aligns store data/strobes and extracts plus sign/zero-extends load data.
// PARAMETERS
//  XLEN       64  data width; bus data = XLEN, strobes = XLEN/8
//  BUS_ADDR_W 64  bus address width; low bits of addr_i are forwarded unchanged
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset, asynchronous, active-high
//  mem_read_i   in   1        MEMP holds a load
//  mem_write_i  in   1        MEMP holds a store (never together with mem_read_i)
//  funct3_i     in   3        000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//  addr_i       in   XLEN     effective address
//  wdata_i      in   XLEN     store data, right-justified
//  state        out  2        00 IDLE, 01 REQ, 10 WAIT; nonzero = busy (to hazard unit)
//  load_data_o  out  XLEN     extended load result, held until the next accepted request
//  done_o       out  1        1-cycle pulse, access complete; MEMR captures load_data_o this cycle
//  misalign_o   out  1        1-cycle pulse, misaligned access dropped
//  req_valid_o  out  1        bus request valid
//  req_ready_i  in   1        bus request accepted
//  req_we_o     out  1        1 = write
//  req_addr_o   out  BUS_ADDR_W  doubleword-aligned address (addr[2:0] forced to 0)
//  req_wdata_o  out  XLEN     wdata_i shifted left by addr[2:0]*8
//  req_wstrb_o  out  XLEN/8   size mask shifted by addr[2:0]; 0 for reads
//  resp_valid_i in   1        read data / write ack
//  resp_rdata_i in   XLEN     read data (ignored for writes)
// BEHAVIOUR
//  Reset: fsm=IDLE, done_q=0, load_data_o=0, misalign_o=0. state=00 and req_valid_o=0 while rst is high.
//  fresh = (mem_read_i|mem_write_i) & ~done_q. done_q is set on completion and cleared unconditionally the next cycle.
//  state output is combinational: 01 when fsm=IDLE & fresh & aligned; otherwise the fsm encoding.
//   This stalls MEMP in the same cycle the request first appears.
//  req_valid_o = (IDLE & fresh & aligned) | REQ. Bus fields are driven from live inputs; MEMP is stalled, so they stay stable.
//  IDLE: fresh & aligned & req_ready_i -> WAIT; fresh & aligned & ~req_ready_i -> REQ; else stay.
//  REQ: req_ready_i -> WAIT; hold req_valid_o and all request fields until accepted.
//  WAIT: req_valid_o=0. On resp_valid_i -> IDLE, done_q<=1, and latch the extended load data (reads only).
//  Extended load data = (resp_rdata_i >> addr[2:0]*8), sign- or zero-extended per funct3, using addr/funct3 latched at issue.
//  Minimum access: accept cycle 0, resp cycle 1, done_o cycle 2. Busy spans 2 cycles.
//   Back-to-back accesses have one idle cycle between them.
//  Alignment: H requires addr[0]=0, W requires addr[1:0]=0, D requires addr[2:0]=0.
//   A misaligned access in IDLE issues no bus request and keeps state=00.
//   It pulses misalign_o and done_o in the same cycle, sets done_q, and sets load_data_o=0.
//  Store: load_data_o is unchanged; completion waits for resp_valid_i as the write ack.
//  resp_valid_i in IDLE or REQ is ignored (stale response after reset). req_ready_i outside IDLE/REQ is ignored.
//  funct3=111 is treated as D.
//  Reset mid-transaction returns to IDLE immediately; the outstanding bus response is dropped.
// STRUCTURE
//  mem_ctrl_pkg: typedef enum logic [1:0] {MS_IDLE=2'b00, MS_REQ=2'b01, MS_WAIT=2'b10} mem_state_t;
//   funct3 size constants; the alignment-check function.
//  Sub-module load_extend (combinational): rdata, offset[2:0], funct3 -> extended XLEN result.
//   The store-side shift/strobe logic stays inline.
// TESTING
//  LD 0x1000, ready=1, resp 1 cycle later with 0x1122334455667788 -> state 01,10,00; done_o cycle 2; load_data_o=0x1122334455667788.
//  LB 0x1003, rdata 0x00000000_80000000 -> load_data_o=0xFFFFFFFFFFFFFF80. Same with LBU -> 0x80.
//  SH 0x1006, wdata 0xBEEF, req_ready low 3 cycles -> state 01 held 4 cycles with stable fields;
//   req_wstrb_o=0xC0; req_wdata_o[63:48]=0xBEEF; done_o after ack.
//  LW 0x1002 -> no req_valid_o; state stays 00; misalign_o=done_o=1 one cycle; load_data_o=0.
//  Two LD back-to-back (MEMP advances on done) -> second req_valid_o exactly one cycle after done_o; no duplicate issue of the first.
//  rst asserted in WAIT, then a late resp_valid_i -> state 00 immediately; no done_o; load_data_o=0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access controller.
// Holds the controller state encoding, funct3 size codes and the alignment rule.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_REQ  = 2'b01,
        MS_WAIT = 2'b10
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Size is funct3[1:0] for every code, so 111 falls into the doubleword rule.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] offset);
        logic ok;
        case (funct3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = (offset[0] == 1'b0);
            2'b10:   ok = (offset[1:0] == 2'b00);
            default: ok = (offset == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load data extraction: shifts the bus doubleword down to the addressed byte lane
// and sign- or zero-extends it according to funct3.
module load_extend
    import mem_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_W:    result = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_BU:   result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_WU:   result = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one outstanding valid/ready bus access,
// busy state for the hazard unit, store lane alignment and load extension.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int BUS_ADDR_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [XLEN-1:0]       addr_i,
    input  logic [XLEN-1:0]       wdata_i,
    output logic [1:0]            state,
    output logic [XLEN-1:0]       load_data_o,
    output logic                  done_o,
    output logic                  misalign_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic                  req_we_o,
    output logic [BUS_ADDR_W-1:0] req_addr_o,
    output logic [XLEN-1:0]       req_wdata_o,
    output logic [XLEN/8-1:0]     req_wstrb_o,
    input  logic                  resp_valid_i,
    input  logic [XLEN-1:0]       resp_rdata_i
);

    mem_state_t        fsm;
    logic              done_q;
    logic              misalign_q;
    logic              we_q;
    logic [2:0]        off_q;
    logic [2:0]        f3_q;
    logic              fresh;
    logic              aligned;
    logic              start;
    logic [XLEN-1:0]   ext_data;
    logic [XLEN/8-1:0] size_mask;

    // done_q masks the instruction still sitting in MEMP during the completion cycle.
    assign fresh   = (mem_read_i | mem_write_i) & ~done_q;
    assign aligned = is_aligned(funct3_i, addr_i[2:0]);
    assign start   = ~rst & (fsm == MS_IDLE) & fresh & aligned;

    // Busy is raised combinationally so MEMP stalls in the cycle the request appears.
    assign state       = start ? MS_REQ : fsm;
    assign req_valid_o = start | (fsm == MS_REQ);

    always_comb begin
        size_mask = '0;
        case (funct3_i[1:0])
            2'b00:   size_mask[0]   = 1'b1;
            2'b01:   size_mask[1:0] = '1;
            2'b10:   size_mask[3:0] = '1;
            default: size_mask      = '1;
        endcase
    end

    assign req_we_o    = mem_write_i;
    assign req_addr_o  = {addr_i[BUS_ADDR_W-1:3], 3'b000};
    assign req_wdata_o = wdata_i << {addr_i[2:0], 3'b000};
    assign req_wstrb_o = mem_write_i ? (size_mask << addr_i[2:0]) : '0;

    assign done_o     = done_q;
    assign misalign_o = misalign_q;

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .rdata  (resp_rdata_i),
        .offset (off_q),
        .funct3 (f3_q),
        .result (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm         <= MS_IDLE;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            load_data_o <= '0;
            we_q        <= 1'b0;
            off_q       <= '0;
            f3_q        <= '0;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            case (fsm)
                MS_IDLE: begin
                    if (fresh) begin
                        if (aligned) begin
                            we_q  <= mem_write_i;
                            off_q <= addr_i[2:0];
                            f3_q  <= funct3_i;
                            fsm   <= req_ready_i ? MS_WAIT : MS_REQ;
                        end else begin
                            done_q      <= 1'b1;
                            misalign_q  <= 1'b1;
                            load_data_o <= '0;
                        end
                    end
                end
                MS_REQ: begin
                    if (req_ready_i) begin
                        fsm <= MS_WAIT;
                    end
                end
                MS_WAIT: begin
                    if (resp_valid_i) begin
                        fsm    <= MS_IDLE;
                        done_q <= 1'b1;
                        if (!we_q) begin
                            load_data_o <= ext_data;
                        end
                    end
                end
                default: fsm <= MS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [63:0] addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic [1:0]  state;
    logic [63:0] load_data_o;
    logic        done_o;
    logic        misalign_o;
    logic        req_valid_o;
    logic        req_ready_i = 1'b0;
    logic        req_we_o;
    logic [63:0] req_addr_o;
    logic [63:0] req_wdata_o;
    logic [7:0]  req_wstrb_o;
    logic        resp_valid_i = 1'b0;
    logic [63:0] resp_rdata_i = '0;

    int unsigned checks = 0;
    int unsigned failures = 0;

    mem_access_ctrl #(
        .XLEN(64),
        .BUS_ADDR_W(64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .state        (state),
        .load_data_o  (load_data_o),
        .done_o       (done_o),
        .misalign_o   (misalign_o),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .req_we_o     (req_we_o),
        .req_addr_o   (req_addr_o),
        .req_wdata_o  (req_wdata_o),
        .req_wstrb_o  (req_wstrb_o),
        .resp_valid_i (resp_valid_i),
        .resp_rdata_i (resp_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_aligned(input logic [2:0] f3, input logic [63:0] a);
        logic [63:0] nbytes;
        nbytes = 64'd1 << f3[1:0];
        return (a % nbytes) == 64'd0;
    endfunction

    function automatic logic [63:0] model_ext(input logic [63:0] rd, input logic [2:0] off,
                                              input logic [2:0] f3);
        int unsigned bits;
        logic [63:0] v;
        logic [63:0] m;
        bits = 8 << f3[1:0];
        v = rd >> (int'(off) * 8);
        if (bits == 64) return v;
        m = (64'd1 << bits) - 64'd1;
        v = v & m;
        if (!f3[2] && v[bits-1]) v = v | ~m;
        return v;
    endfunction

    // Transaction-level model: is a bus access waiting for its response, is a request
    // being presented, and what completion pulses / load value are due next.
    logic        m_wait = 1'b0;
    logic        m_hold = 1'b0;
    logic        m_done = 1'b0;
    logic        m_mis  = 1'b0;
    logic        m_we   = 1'b0;
    logic [2:0]  m_off  = '0;
    logic [2:0]  m_f3   = '0;
    logic [63:0] m_load = '0;

    always @(negedge clk) begin : compare
        logic fresh;
        logic al;
        logic present;
        logic n_done;
        logic n_mis;
        int unsigned nb;
        logic [15:0] sm;
        if (rst) begin
            chk("rst_state", 64'(state), 64'd0);
            chk("rst_req_valid", 64'(req_valid_o), 64'd0);
            chk("rst_done", 64'(done_o), 64'd0);
            chk("rst_misalign", 64'(misalign_o), 64'd0);
            chk("rst_load_data", load_data_o, 64'd0);
            m_wait = 1'b0;
            m_hold = 1'b0;
            m_done = 1'b0;
            m_mis  = 1'b0;
            m_load = '0;
        end else begin
            fresh   = (mem_read_i || mem_write_i) && !m_done;
            al      = model_aligned(funct3_i, addr_i);
            present = m_hold || (!m_wait && fresh && al);
            chk("state", 64'(state), m_wait ? 64'd2 : (present ? 64'd1 : 64'd0));
            chk("req_valid", 64'(req_valid_o), 64'(present));
            chk("done", 64'(done_o), 64'(m_done));
            chk("misalign", 64'(misalign_o), 64'(m_mis));
            chk("load_data", load_data_o, m_load);
            if (present) begin
                nb = 1 << funct3_i[1:0];
                sm = 16'(((32'd1 << nb) - 32'd1) << addr_i[2:0]);
                chk("req_we", 64'(req_we_o), 64'(mem_write_i));
                chk("req_addr", req_addr_o, addr_i & ~64'h7);
                chk("req_wdata", req_wdata_o, wdata_i << (int'(addr_i[2:0]) * 8));
                chk("req_wstrb", 64'(req_wstrb_o), mem_write_i ? 64'(sm[7:0]) : 64'd0);
            end
            n_done = 1'b0;
            n_mis  = 1'b0;
            if (m_wait) begin
                if (resp_valid_i) begin
                    m_wait = 1'b0;
                    n_done = 1'b1;
                    if (!m_we) m_load = model_ext(resp_rdata_i, m_off, m_f3);
                end
            end else if (present) begin
                if (!m_hold) begin
                    m_we  = mem_write_i;
                    m_off = addr_i[2:0];
                    m_f3  = funct3_i;
                end
                if (req_ready_i) begin
                    m_wait = 1'b1;
                    m_hold = 1'b0;
                end else begin
                    m_hold = 1'b1;
                end
            end else if (fresh && !al) begin
                n_done = 1'b1;
                n_mis  = 1'b1;
                m_load = '0;
            end
            m_done = n_done;
            m_mis  = n_mis;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one MEMP access and plays the bus: ready after rdy_dly cycles, response
    // the cycle after acceptance. Returns in the done cycle with the request dropped.
    task automatic access(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata,
                          input int unsigned rdy_dly,
                          output int unsigned busy, output int unsigned vcyc,
                          output int unsigned first_v, output logic got_done,
                          output logic stable, output logic [7:0] strb0,
                          output logic [63:0] wdat0);
        logic acc;
        logic [63:0] addr0;
        busy = 0;
        vcyc = 0;
        first_v = 99;
        got_done = 1'b0;
        stable = 1'b1;
        strb0 = '0;
        wdat0 = '0;
        addr0 = '0;
        mem_read_i = !wr;
        mem_write_i = wr;
        funct3_i = f3;
        addr_i = addr;
        wdata_i = wdata;
        resp_rdata_i = rdata;
        resp_valid_i = 1'b0;
        req_ready_i = (rdy_dly == 0);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (state != 2'b00) busy++;
            if (req_valid_o) begin
                if (vcyc == 0) begin
                    first_v = i;
                    strb0 = req_wstrb_o;
                    wdat0 = req_wdata_o;
                    addr0 = req_addr_o;
                end else if (req_wstrb_o !== strb0 || req_wdata_o !== wdat0 ||
                             req_addr_o !== addr0) begin
                    stable = 1'b0;
                end
                vcyc++;
            end
            if (done_o && i > 0) begin
                got_done = 1'b1;
                break;
            end
            acc = req_valid_o && req_ready_i;
            @(posedge clk);
            #1;
            resp_valid_i = acc;
            req_ready_i = (i + 1 >= rdy_dly);
        end
        mem_read_i = 1'b0;
        mem_write_i = 1'b0;
        resp_valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned busy;
        int unsigned vc;
        int unsigned fv;
        logic gd;
        logic stab;
        logic [7:0] s0;
        logic [63:0] w0;
        logic active;
        logic wr;
        logic [2:0] am;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cyc();

        access(1'b0, 3'b011, 64'h1000, '0, 64'h1122334455667788, 0, busy, vc, fv, gd, stab, s0, w0);
        chk("ld_done", 64'(gd), 64'd1);
        chk("ld_busy_cycles", 64'(busy), 64'd2);
        chk("ld_data", load_data_o, 64'h1122334455667788);
        cyc();

        access(1'b0, 3'b000, 64'h1003, '0, 64'h0000000080000000, 0, busy, vc, fv, gd, stab, s0, w0);
        chk("lb_data", load_data_o, 64'hFFFFFFFFFFFFFF80);
        cyc();
        access(1'b0, 3'b100, 64'h1003, '0, 64'h0000000080000000, 0, busy, vc, fv, gd, stab, s0, w0);
        chk("lbu_data", load_data_o, 64'h0000000000000080);
        cyc();

        access(1'b1, 3'b001, 64'h1006, 64'hBEEF, '0, 3, busy, vc, fv, gd, stab, s0, w0);
        chk("sh_done", 64'(gd), 64'd1);
        chk("sh_req_cycles", 64'(vc), 64'd4);
        chk("sh_busy_cycles", 64'(busy), 64'd5);
        chk("sh_fields_stable", 64'(stab), 64'd1);
        chk("sh_wstrb", 64'(s0), 64'hC0);
        chk("sh_wdata_hi", 64'(w0[63:48]), 64'hBEEF);
        chk("sh_load_kept", load_data_o, 64'h0000000000000080);
        cyc();

        access(1'b0, 3'b010, 64'h1002, '0, '1, 0, busy, vc, fv, gd, stab, s0, w0);
        chk("lw_mis_done", 64'(gd), 64'd1);
        chk("lw_mis_no_req", 64'(vc), 64'd0);
        chk("lw_mis_busy", 64'(busy), 64'd0);
        chk("lw_mis_pulse", 64'(misalign_o), 64'd1);
        chk("lw_mis_load", load_data_o, 64'd0);
        cyc();
        chk("lw_mis_pulse_end", 64'(misalign_o), 64'd0);

        access(1'b0, 3'b011, 64'h2000, '0, 64'hA5A5A5A5_01234567, 0, busy, vc, fv, gd, stab, s0, w0);
        chk("b2b_first_done", 64'(gd), 64'd1);
        chk("b2b_first_issues", 64'(vc), 64'd1);
        access(1'b0, 3'b011, 64'h2008, '0, 64'h0F0E0D0C_0B0A0908, 0, busy, vc, fv, gd, stab, s0, w0);
        chk("b2b_gap", 64'(fv), 64'd1);
        chk("b2b_second_issues", 64'(vc), 64'd1);
        chk("b2b_second_data", load_data_o, 64'h0F0E0D0C_0B0A0908);
        cyc();

        mem_read_i = 1'b1;
        funct3_i = 3'b011;
        addr_i = 64'h3000;
        req_ready_i = 1'b1;
        resp_valid_i = 1'b0;
        #1 chk("rw_issue_state", 64'(state), 64'd1);
        cyc();
        chk("rw_wait_state", 64'(state), 64'd2);
        rst = 1'b1;
        mem_read_i = 1'b0;
        req_ready_i = 1'b0;
        #1;
        chk("rw_rst_state", 64'(state), 64'd0);
        chk("rw_rst_load", load_data_o, 64'd0);
        cyc();
        rst = 1'b0;
        resp_valid_i = 1'b1;
        resp_rdata_i = 64'hDEADBEEF_CAFEF00D;
        cyc();
        resp_valid_i = 1'b0;
        chk("rw_late_no_done", 64'(done_o), 64'd0);
        chk("rw_late_state", 64'(state), 64'd0);
        chk("rw_late_load", load_data_o, 64'd0);

        active = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                active = 1'b0;
                mem_read_i = 1'b0;
                mem_write_i = 1'b0;
            end
            if (!rst && (!active || done_o)) begin
                if ($urandom_range(0, 3) != 0) begin
                    wr = 1'($urandom_range(0, 1));
                    mem_read_i = !wr;
                    mem_write_i = wr;
                    funct3_i = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
                    addr_i = {$urandom, $urandom};
                    am = 3'((1 << funct3_i[1:0]) - 1);
                    if ($urandom_range(0, 3) != 0) addr_i[2:0] = addr_i[2:0] & ~am;
                    wdata_i = {$urandom, $urandom};
                    active = 1'b1;
                end else begin
                    mem_read_i = 1'b0;
                    mem_write_i = 1'b0;
                    active = 1'b0;
                end
            end
            req_ready_i = ($urandom_range(0, 2) != 0);
            resp_valid_i = 1'($urandom_range(0, 1));
            resp_rdata_i = {$urandom, $urandom};
        end
        rst = 1'b0;
        mem_read_i = 1'b0;
        mem_write_i = 1'b0;
        resp_valid_i = 1'b0;
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
